// File: rtl/serial_seq_pkg.sv
// serial_seq_pkg: shared state encoding, defaults and helpers for the serial frame link
package serial_seq_pkg;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'b001,
        TX_SHIFT = 3'b010,
        TX_GAP   = 3'b100
    } tx_state_e;

    localparam int DEFAULT_FRAME_BITS = 3;

    function automatic logic all_ones(input logic [31:0] word, input int bits);
        logic r;
        r = 1'b1;
        for (int i = 0; i < bits; i++) r = r & word[i];
        return r;
    endfunction

endpackage

// File: rtl/serial_frame_transmitter_if.sv
// serial_frame_transmitter_if: parallel word valid/ready handshake into the transmitter
interface serial_frame_transmitter_if
    import serial_seq_pkg::*;
#(
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS
);
    logic [FRAME_BITS-1:0] Word_In;
    logic                  Word_Valid;
    logic                  Word_Ready;

    modport master (output Word_In, output Word_Valid, input Word_Ready);
    modport slave  (input Word_In, input Word_Valid, output Word_Ready);
endinterface

// File: rtl/serial_hold_buffer.sv
// serial_hold_buffer: one-entry word register between the handshake and the shifter
module serial_hold_buffer #(
    parameter int W = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] word_in,
    input  logic         word_valid,
    output logic         word_ready,
    input  logic         load,
    output logic         hold_full,
    output logic [W-1:0] hold_word
);
    logic         full_q, full_d;
    logic [W-1:0] word_q, word_d;
    logic         accept;

    assign accept     = word_valid && !full_q;
    assign word_ready = !full_q;
    assign hold_full  = full_q;
    assign hold_word  = word_q;

    // load only fires while full, so it can never coincide with an accept
    always_comb begin
        full_d = load ? 1'b0 : accept ? 1'b1 : full_q;
        word_d = accept ? word_in : word_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/serial_frame_transmitter.sv
// serial_frame_transmitter: shifts handshaked words out MSB-first as framed serial bits
module serial_frame_transmitter
    import serial_seq_pkg::*;
#(
    parameter int   FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic Clock,
    input  logic Reset,
    serial_frame_transmitter_if.slave word_if,
    output logic Data_Out,
    output logic Bit_Valid,
    output logic Frame_Start,
    output logic Frame_End,
    output logic All_Ones_Sent,
    output logic Busy
);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    tx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, hold_word;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic                  ones_q, ones_d;
    logic                  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  start_q, start_d;
    logic                  end_q, end_d;
    logic                  aos_q, aos_d;
    logic                  hold_full, load, last_bit;

    serial_hold_buffer #(.W(FRAME_BITS)) u_hold (
        .Clock      (Clock),
        .Reset      (Reset),
        .word_in    (word_if.Word_In),
        .word_valid (word_if.Word_Valid),
        .word_ready (word_if.Word_Ready),
        .load       (load),
        .hold_full  (hold_full),
        .hold_word  (hold_word)
    );

    assign last_bit = state_q == TX_SHIFT && bit_idx_q == LAST_IDX;
    // a held word loads from IDLE, straight after a last bit when contiguous, or on the final gap cycle
    assign load = hold_full && (state_q == TX_IDLE || (last_bit && GAP_CYCLES == 0) ||
                                (state_q == TX_GAP && gap_q == LAST_GAP));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        gap_d     = gap_q;
        ones_d    = ones_q;
        data_d    = IDLE_LEVEL;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        end_d     = 1'b0;
        if (load) begin
            state_d   = TX_SHIFT;
            shift_d   = hold_word;
            bit_idx_d = '0;
            ones_d    = all_ones(32'(hold_word), FRAME_BITS);
            data_d    = hold_word[FRAME_BITS-1];
            valid_d   = 1'b1;
            start_d   = 1'b1;
        end else if (state_q == TX_SHIFT && !last_bit) begin
            shift_d   = shift_q << 1;
            bit_idx_d = bit_idx_q + 1'b1;
            data_d    = shift_q[FRAME_BITS-2];
            valid_d   = 1'b1;
            end_d     = bit_idx_q == LAST_IDX - 1'b1;
        end else if (last_bit) begin
            state_d = GAP_CYCLES > 0 ? TX_GAP : TX_IDLE;
            gap_d   = '0;
        end else if (state_q == TX_GAP) begin
            gap_d   = gap_q + 1'b1;
            state_d = gap_q == LAST_GAP ? TX_IDLE : TX_GAP;
        end
        aos_d = end_d && ones_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            gap_q     <= '0;
            ones_q    <= 1'b0;
            data_q    <= IDLE_LEVEL;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            aos_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            gap_q     <= gap_d;
            ones_q    <= ones_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            end_q     <= end_d;
            aos_q     <= aos_d;
        end
    end

    assign Data_Out      = data_q;
    assign Bit_Valid     = valid_q;
    assign Frame_Start   = start_q;
    assign Frame_End     = end_q;
    assign All_Ones_Sent = aos_q;
    assign Busy          = state_q != TX_IDLE || hold_full;
endmodule

// File: tb/tb_serial_frame_transmitter.sv
// tb_serial_frame_transmitter: scenario tasks plus a word scoreboard for the frame transmitter
module tb_serial_frame_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    serial_frame_transmitter_if #(.FRAME_BITS(3)) if0 ();
    serial_frame_transmitter_if #(.FRAME_BITS(3)) if1 ();

    logic d0, v0, fs0, fe0, aos0, busy0;
    logic d1, v1, fs1, fe1, aos1, busy1;

    serial_frame_transmitter #(.FRAME_BITS(3), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
        .Clock(clk), .Reset(rst), .word_if(if0.slave), .Data_Out(d0), .Bit_Valid(v0),
        .Frame_Start(fs0), .Frame_End(fe0), .All_Ones_Sent(aos0), .Busy(busy0)
    );

    serial_frame_transmitter #(.FRAME_BITS(3), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1)) dut1 (
        .Clock(clk), .Reset(rst), .word_if(if1.slave), .Data_Out(d1), .Bit_Valid(v1),
        .Frame_Start(fs1), .Frame_End(fe1), .All_Ones_Sent(aos1), .Busy(busy1)
    );

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL reset_data0: got %b want 0", d0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", v0); end
        checks++; if (if0.Word_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b want 1", if0.Word_Ready); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL reset_idle_level1: got %b want 1", d1); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b want 0", v1); end
        rst = 1'b0;
    endtask

    task automatic test_single;
        logic [2:0] w;
        w = 3'b101;
        @(posedge clk); #1;
        if0.Word_In = w;
        if0.Word_Valid = 1'b1;
        @(posedge clk); #1;
        if0.Word_Valid = 1'b0;
        checks++; if ({if0.Word_Ready, busy0, v0} !== 3'b010) begin
            errors++; $display("FAIL single_held: ready/busy/valid got %b want 010", {if0.Word_Ready, busy0, v0});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if ({v0, d0} !== {1'b1, w[2-i]}) begin
                errors++; $display("FAIL single_bit%0d: valid/data got %b want 1%b", i, {v0, d0}, w[2-i]);
            end
            checks++; if ({fs0, fe0, aos0} !== {i == 0, i == 2, 1'b0}) begin
                errors++; $display("FAIL single_flags%0d: start/end/aos got %b want %b", i, {fs0, fe0, aos0}, {i == 0, i == 2, 1'b0});
            end
        end
        @(posedge clk); #1;
        checks++; if ({v0, busy0, if0.Word_Ready} !== 3'b001) begin
            errors++; $display("FAIL single_idle: valid/busy/ready got %b want 001", {v0, busy0, if0.Word_Ready});
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] words [2];
        logic bq[$];
        logic acc, eb;
        int nw, held, nvalid, first, last;
        words[0] = 3'b111; words[1] = 3'b011;
        nw = 0; held = 0; nvalid = 0; first = -1; last = -1; acc = 1'b0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(posedge clk); #1;
            if (acc) begin held++; if0.Word_Valid = 1'b0; end
            if (!if0.Word_Valid && nw < 2) begin
                if0.Word_In = words[nw]; if0.Word_Valid = 1'b1; nw++;
            end
            acc = if0.Word_Valid && if0.Word_Ready;
            if (acc) for (int b = 2; b >= 0; b--) bq.push_back(if0.Word_In[b]);
            @(negedge clk);
            if (held == 2 && nvalid < 3) begin
                checks++; if (if0.Word_Ready !== 1'b0) begin
                    errors++; $display("FAIL b2b_ready_held: got %b want 0", if0.Word_Ready);
                end
            end
            if (v0) begin
                if (first < 0) first = cyc;
                last = cyc;
                nvalid++;
                eb = bq.size() > 0 ? bq.pop_front() : 1'bx;
                checks++; if (d0 !== eb) begin errors++; $display("FAIL b2b_bit%0d: got %b want %b", nvalid, d0, eb); end
                checks++; if (aos0 !== (nvalid == 3)) begin
                    errors++; $display("FAIL b2b_aos%0d: got %b want %b", nvalid, aos0, nvalid == 3);
                end
            end
        end
        checks++; if (nvalid != 6 || last - first != 5) begin
            errors++; $display("FAIL b2b_contiguous: got %0d bits over %0d cycles want 6 over 6", nvalid, last - first + 1);
        end
    endtask

    task automatic test_gap;
        logic [2:0] words [2];
        logic ev [8];
        logic ed [8];
        logic acc;
        int nw, idx;
        words[0] = 3'b010; words[1] = 3'b100;
        ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ed = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        nw = 0; idx = 0; acc = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(posedge clk); #1;
            if (acc) if1.Word_Valid = 1'b0;
            if (!if1.Word_Valid && nw < 2) begin
                if1.Word_In = words[nw]; if1.Word_Valid = 1'b1; nw++;
            end
            acc = if1.Word_Valid && if1.Word_Ready;
            @(negedge clk);
            if ((v1 || idx > 0) && idx < 8) begin
                checks++; if ({v1, d1} !== {ev[idx], ed[idx]}) begin
                    errors++; $display("FAIL gap_sample%0d: valid/data got %b want %b", idx, {v1, d1}, {ev[idx], ed[idx]});
                end
                checks++; if ({fs1, fe1, aos1} !== {idx == 0 || idx == 5, idx == 2 || idx == 7, 1'b0}) begin
                    errors++; $display("FAIL gap_flags%0d: start/end/aos got %b", idx, {fs1, fe1, aos1});
                end
                idx++;
            end
        end
        checks++; if (idx != 8 || busy1 !== 1'b0) begin
            errors++; $display("FAIL gap_done: samples %0d busy %b want 8 and 0", idx, busy1);
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        @(posedge clk); #1;
        if0.Word_In = 3'b110; if0.Word_Valid = 1'b1;
        @(posedge clk); #1;
        if0.Word_In = 3'b111;
        @(posedge clk); #1;
        checks++; if ({v0, d0, fs0} !== 3'b111) begin
            errors++; $display("FAIL rmid_bit1: valid/data/start got %b want 111", {v0, d0, fs0});
        end
        @(posedge clk); #1;
        if0.Word_Valid = 1'b0;
        checks++; if ({v0, d0, if0.Word_Ready} !== 3'b110) begin
            errors++; $display("FAIL rmid_bit2: valid/data/ready got %b want 110", {v0, d0, if0.Word_Ready});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({v0, if0.Word_Ready, busy0} !== 3'b010) begin
            errors++; $display("FAIL rmid_after: valid/ready/busy got %b want 010", {v0, if0.Word_Ready, busy0});
        end
        repeat (8) begin
            @(negedge clk);
            if (v0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rmid_discard: got %0d stray bits want 0", stray); end
    endtask

    task automatic test_random;
        logic [2:0] exp_q[$];
        logic [2:0] cur, ew;
        logic acc, det;
        int issued, rcvd, n, run, budget;
        issued = 0; rcvd = 0; n = 0; run = 0; budget = 0; cur = '0; acc = 1'b0;
        while (rcvd < 200 && budget < 3000) begin
            budget++;
            @(posedge clk); #1;
            if (acc) if0.Word_Valid = 1'b0;
            if (!if0.Word_Valid && issued < 200 && $urandom_range(0, 3) != 0) begin
                if0.Word_In = $urandom_range(0, 3) == 0 ? 3'b111 : 3'($urandom);
                if0.Word_Valid = 1'b1;
                issued++;
            end
            acc = if0.Word_Valid && if0.Word_Ready;
            if (acc) exp_q.push_back(if0.Word_In);
            @(negedge clk);
            if (!v0) begin
                run = 0;
                checks++; if ({fs0, fe0, aos0} !== 3'b000) begin
                    errors++; $display("FAIL rand_idle_flags: got %b want 000", {fs0, fe0, aos0});
                end
            end else begin
                if (fs0) begin n = 0; run = 0; end
                cur = {cur[1:0], d0};
                n++;
                run = d0 ? run + 1 : 0;
                det = fe0 && run == 3;
                checks++; if (aos0 !== det) begin errors++; $display("FAIL rand_aos: got %b want %b", aos0, det); end
                if (fe0) begin
                    rcvd++;
                    ew = exp_q.size() > 0 ? exp_q.pop_front() : 3'bxxx;
                    checks++; if (n != 3 || cur !== ew) begin
                        errors++; $display("FAIL rand_frame%0d: got %b (%0d bits) want %b", rcvd, cur, n, ew);
                    end
                end
            end
        end
        if0.Word_Valid = 1'b0;
        checks++; if (rcvd != 200 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_count: got %0d frames, %0d left want 200, 0", rcvd, exp_q.size());
        end
    endtask

    initial begin
        if0.Word_In = '0; if0.Word_Valid = 1'b0;
        if1.Word_In = '0; if1.Word_Valid = 1'b0;
        test_reset;
        test_single;
        test_back_to_back;
        test_gap;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
